// File: rtl/vidmem_target.sv
// ============================================================================
// vidmem_target : pixel frame-buffer bus target (write/read bursts, arbiter bid)
// Rev 1.0
// ============================================================================
`default_nettype none

module vidmem_target #(
    parameter int         DEPTH   = 256,
    parameter logic [3:0] INIT_ID = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [2:0]  cmdout,
    output logic [3:0]  reqtar
);

    localparam int       AW          = $clog2(DEPTH);
    localparam logic [2:0] c_CMD_WDATA = 3'b001;
    localparam logic [2:0] c_CMD_RREQ  = 3'b010;
    localparam logic [2:0] c_CMD_RDATA = 3'b011;
    localparam logic [2:0] c_CMD_WREQ  = 3'b100;
    localparam logic [2:0] c_CMD_WRESP = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_ARB     = 3'd2,
        S_RD_DATA = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_addr, w_addr_nx;
    logic [31:0] r_req_addr, w_req_addr_nx;
    logic [1:0]  r_len, w_len_nx;
    logic [3:0]  r_cnt, w_cnt_nx;
    logic        r_is_wr, w_is_wr_nx;

    logic [1:0]  r_reqout, w_reqout_nx;
    logic [1:0]  r_lenout, w_lenout_nx;
    logic [31:0] r_addrdataout, w_addrdataout_nx;
    logic [2:0]  r_cmdout, w_cmdout_nx;
    logic [3:0]  r_reqtar, w_reqtar_nx;

    logic        w_mem_we;
    logic [3:0]  w_beats;
    logic [AW-1:0] w_idx;
    logic [31:0] r_mem [DEPTH];

    assign w_beats = 4'd1 << r_len;
    // Byte address bits [1:0] are dropped; the upper bits wrap the word index.
    assign w_idx   = r_addr[AW+1:2];

    always_comb begin
        w_state_nx       = r_state;
        w_addr_nx        = r_addr;
        w_req_addr_nx    = r_req_addr;
        w_len_nx         = r_len;
        w_cnt_nx         = r_cnt;
        w_is_wr_nx       = r_is_wr;
        w_mem_we         = 1'b0;
        w_reqout_nx      = 2'b00;
        w_lenout_nx      = 2'b00;
        w_addrdataout_nx = 32'd0;
        w_cmdout_nx      = 3'b000;
        w_reqtar_nx      = 4'd0;

        case (r_state)
            S_IDLE: begin
                if (selin && (cmdin == c_CMD_WREQ)) begin
                    w_addr_nx     = addrdatain;
                    w_req_addr_nx = addrdatain;
                    w_len_nx      = lenin;
                    w_cnt_nx      = 4'd0;
                    w_state_nx    = S_WR_DATA;
                end else if (selin && (cmdin == c_CMD_RREQ)) begin
                    w_addr_nx     = addrdatain;
                    w_req_addr_nx = addrdatain;
                    w_len_nx      = lenin;
                    w_cnt_nx      = 4'd0;
                    w_is_wr_nx    = 1'b0;
                    w_state_nx    = S_ARB;
                    w_reqout_nx   = 2'b11;
                    w_reqtar_nx   = INIT_ID;
                end
            end
            S_WR_DATA: begin
                if (selin && (cmdin == c_CMD_WDATA)) begin
                    w_mem_we  = 1'b1;
                    w_addr_nx = r_addr + 32'd4;
                    w_cnt_nx  = r_cnt + 4'd1;
                    if ((r_cnt + 4'd1) == w_beats) begin
                        w_is_wr_nx  = 1'b1;
                        w_state_nx  = S_ARB;
                        w_reqout_nx = 2'b11;
                        w_reqtar_nx = INIT_ID;
                    end
                end
            end
            S_ARB: begin
                if (!ackin) begin
                    w_reqout_nx = 2'b11;
                    w_reqtar_nx = INIT_ID;
                end else if (r_is_wr) begin
                    w_state_nx       = S_WR_RESP;
                    w_cmdout_nx      = c_CMD_WRESP;
                    w_lenout_nx      = r_len;
                    w_addrdataout_nx = r_req_addr;
                end else begin
                    // Grant edge launches the first read beat.
                    w_state_nx       = S_RD_DATA;
                    w_cmdout_nx      = c_CMD_RDATA;
                    w_lenout_nx      = r_len;
                    w_addrdataout_nx = r_mem[w_idx];
                    w_addr_nx        = r_addr + 32'd4;
                    w_cnt_nx         = r_cnt + 4'd1;
                end
            end
            S_RD_DATA: begin
                if (r_cnt == w_beats) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cmdout_nx      = c_CMD_RDATA;
                    w_lenout_nx      = r_len;
                    w_addrdataout_nx = r_mem[w_idx];
                    w_addr_nx        = r_addr + 32'd4;
                    w_cnt_nx         = r_cnt + 4'd1;
                end
            end
            S_WR_RESP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= 32'd0;
            r_req_addr    <= 32'd0;
            r_len         <= 2'b00;
            r_cnt         <= 4'd0;
            r_is_wr       <= 1'b0;
            r_reqout      <= 2'b00;
            r_lenout      <= 2'b00;
            r_addrdataout <= 32'd0;
            r_cmdout      <= 3'b000;
            r_reqtar      <= 4'd0;
        end else begin
            r_state       <= w_state_nx;
            r_addr        <= w_addr_nx;
            r_req_addr    <= w_req_addr_nx;
            r_len         <= w_len_nx;
            r_cnt         <= w_cnt_nx;
            r_is_wr       <= w_is_wr_nx;
            r_reqout      <= w_reqout_nx;
            r_lenout      <= w_lenout_nx;
            r_addrdataout <= w_addrdataout_nx;
            r_cmdout      <= w_cmdout_nx;
            r_reqtar      <= w_reqtar_nx;
        end
    end

    // Frame-buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= addrdatain;
        end
    end

    assign reqout      = r_reqout;
    assign lenout      = r_lenout;
    assign addrdataout = r_addrdataout;
    assign cmdout      = r_cmdout;
    assign reqtar      = r_reqtar;

endmodule

`default_nettype wire

// File: tb/tb_vidmem_target.sv
// ============================================================================
// tb_vidmem_target : randomized self-checking bench with a word-array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vidmem_target;

    localparam int         DEPTH   = 256;
    localparam logic [3:0] INIT_ID = 4'b0001;
    localparam logic [63:0] c_BID  = {21'b0, 2'b11, 2'b00, 3'b000, INIT_ID, 32'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        selin = 1'b0;
    logic [2:0]  cmdin = 3'b000;
    logic [1:0]  lenin = 2'b00;
    logic [31:0] addrdatain = 32'd0;
    logic        ackin = 1'b0;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;

    logic [31:0] model [DEPTH];
    logic [31:0] wdata [8];
    int          n_vec = 0;
    int          n_err = 0;

    vidmem_target #(.DEPTH(DEPTH), .INIT_ID(INIT_ID)) u_dut (
        .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
        .addrdatain(addrdatain), .ackin(ackin), .reqout(reqout), .lenout(lenout),
        .addrdataout(addrdataout), .cmdout(cmdout), .reqtar(reqtar)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {21'b0, reqout, lenout, cmdout, reqtar, addrdataout};
    endfunction

    function automatic int widx(input logic [31:0] a, input int b);
        return int'(((a >> 2) + 32'(b)) % 32'(DEPTH));
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        selin = 1'b0; cmdin = 3'b000; lenin = 2'b00; addrdatain = 32'd0;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [1:0] len,
                            input int stall_min, input int stall_max, input int ack_dly);
        int L = 1 << len;
        selin = 1'b1; cmdin = 3'b100; addrdatain = addr; lenin = len;
        step();
        for (int b = 0; b < L; b++) begin
            int ns = $urandom_range(stall_max, stall_min);
            for (int s = 0; s < ns; s++) begin
                selin = 1'($urandom);
                cmdin = selin ? 3'b000 : 3'b001;
                addrdatain = $urandom;
                step();
                check("wr_stall", outs(), 64'd0);
            end
            selin = 1'b1; cmdin = 3'b001; addrdatain = wdata[b];
            step();
            model[widx(addr, b)] = wdata[b];
            if (b < L - 1) check("wr_beat", outs(), 64'd0);
        end
        bus_idle();
        check("wr_bid", outs(), c_BID);
        for (int d = 0; d < ack_dly; d++) begin
            selin = 1'($urandom); cmdin = 3'($urandom); addrdatain = $urandom;
            step();
            check("wr_bid_hold", outs(), c_BID);
        end
        bus_idle();
        ackin = 1'b1;
        step();
        ackin = 1'b0;
        check("wr_resp", outs(), {21'b0, 2'b00, len, 3'b101, 4'b0, addr});
        step();
        check("wr_done", outs(), 64'd0);
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [1:0] len,
                            input int ack_dly, input bit inject);
        int L = 1 << len;
        selin = 1'b1; cmdin = 3'b010; addrdatain = addr; lenin = len;
        step();
        bus_idle();
        check("rd_bid", outs(), c_BID);
        for (int d = 0; d < ack_dly; d++) begin
            selin = 1'($urandom); cmdin = 3'($urandom); addrdatain = $urandom;
            step();
            check("rd_bid_hold", outs(), c_BID);
        end
        bus_idle();
        ackin = 1'b1;
        step();
        ackin = 1'b0;
        for (int b = 0; b < L; b++) begin
            check("rd_beat", outs(), {21'b0, 2'b00, len, 3'b011, 4'b0, model[widx(addr, b)]});
            if (inject && b == 0) begin
                selin = 1'b1; cmdin = 3'b010; addrdatain = $urandom; lenin = ~len;
            end else begin
                bus_idle();
            end
            step();
        end
        bus_idle();
        check("rd_done", outs(), 64'd0);
    endtask

    initial begin
        // Asynchronous power-on reset, asserted between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check("por_async", outs(), 64'd0);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("por_idle", outs(), 64'd0);
        end

        // Preload every word so the model is fully defined.
        for (int i = 0; i < DEPTH / 8; i++) begin
            for (int b = 0; b < 8; b++) wdata[b] = $urandom;
            wr_burst(32'(i * 32), 2'b11, 0, 0, 0);
        end

        // Write then read back a 4-beat burst.
        wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
        wr_burst(32'h100, 2'b10, 0, 0, 1);
        rd_burst(32'h100, 2'b10, 0, 1'b0);

        // Stalled 2-beat write with a six-cycle grant delay.
        wdata[0] = $urandom; wdata[1] = $urandom;
        wr_burst(32'h200, 2'b01, 1, 2, 6);
        rd_burst(32'h200, 2'b01, 6, 1'b0);

        // Word-index wrap at the top of the buffer.
        for (int b = 0; b < 8; b++) wdata[b] = 32'hA500_0000 + 32'(b);
        wr_burst(32'h3F8, 2'b11, 0, 0, 0);
        rd_burst(32'h3F8, 2'b11, 0, 1'b0);

        // Unselected request and stray grant are both ignored.
        selin = 1'b0; cmdin = 3'b010; addrdatain = 32'h100; lenin = 2'b11;
        step();
        check("no_sel_bid", outs(), 64'd0);
        bus_idle();
        ackin = 1'b1;
        step();
        ackin = 1'b0;
        check("stray_ack", outs(), 64'd0);

        // Second read request during a burst is ignored.
        rd_burst(32'h100, 2'b10, 2, 1'b1);

        // Reset during beat 2 of an 8-beat read.
        selin = 1'b1; cmdin = 3'b010; addrdatain = 32'h100; lenin = 2'b11;
        step();
        bus_idle();
        ackin = 1'b1;
        step();
        ackin = 1'b0;
        check("mid_beat0", outs(), {21'b0, 2'b00, 2'b11, 3'b011, 4'b0, model[widx(32'h100, 0)]});
        step();
        check("mid_beat1", outs(), {21'b0, 2'b00, 2'b11, 3'b011, 4'b0, model[widx(32'h100, 1)]});
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_async", outs(), 64'd0);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mid_rst_idle", outs(), 64'd0);
        end
        rd_burst(32'h100, 2'b11, 1, 1'b0);

        // Randomized mix of write and read bursts.
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            logic [1:0]  ln;
            a  = $urandom;
            if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
            ln = 2'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                for (int b = 0; b < 8; b++) wdata[b] = $urandom;
                wr_burst(a, ln, 0, 2, $urandom_range(3, 0));
            end else begin
                rd_burst(a, ln, $urandom_range(3, 0), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
